rom_port_arbiter: RTL and testbench
===================================

// Module: rom_port_arbiter
// PURPOSE
//  Shares the single byte-wide synchronous read port of the boot ROM between two requesters:
//  instruction fetch (IF) and data load (LD).
//  Each granted request performs four sequential byte reads and returns one 32-bit big-endian word
//  ({addr, addr+1, addr+2, addr+3}). Sits between the fetch stage / load path and the byte ROM.
// PARAMETERS
//  A_WIDTH    32            byte-address width
//  D_WIDTH    8             ROM data width (byte)
//  ROM_BASE   32'hBFC00000  first valid byte address
//  ROM_BYTES  4096          ROM size in bytes; valid range [ROM_BASE, ROM_BASE+ROM_BYTES-1]
// PORTS
//  clk           in   1        clock, rising edge
//  rst_n         in   1        asynchronous active-low reset
//  if_req_valid  in   1        IF request; hold valid and if_addr stable until if_req_ready
//  if_req_ready  out  1        IF request accepted this cycle
//  if_addr       in   A_WIDTH  IF byte address (alignment not required)
//  if_rsp_valid  out  1        one-cycle pulse: if_rdata/if_err valid
//  if_rdata      out  32       assembled word
//  if_err        out  1        one or more of the 4 bytes fell outside the ROM range
//  ld_*          --   --       identical set for the load requester (ld_req_valid ... ld_err)
//  mem_en        out  1        ROM read enable
//  mem_addr      out  A_WIDTH  ROM byte address
//  mem_rdata     in   D_WIDTH  ROM data, valid the cycle after mem_en
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; beat counter 0; both *_req_ready 0; both *_rsp_valid 0.
//    rdata 0; err 0; mem_en 0; mem_addr 0; RR pointer = LD, so IF wins the first tie.
//  - FSM states:
//    IDLE -> ISSUE on handshake (cycle T).
//    ISSUE issues beats 0..3 at T+1..T+4 -> DRAIN at T+5.
//    DRAIN captures the last byte -> IDLE.
//  - Ready is asserted only in IDLE. *_req_ready is a combinational function of IDLE, both valids and the RR pointer.
//  - Arbitration:
//    - If only one requester is valid, it is granted.
//    - If both are valid, the requester not granted last time is granted.
//    - The RR pointer updates on every handshake.
//    - The loser's ready is 0.
//  - On handshake, latch the address and requester id.
//  - Beat k (k=0..3), at cycle T+1+k:
//    - mem_addr = addr+k, modulo 2^A_WIDTH (wrap permitted).
//    - mem_en = 1 only if addr+k is in range.
//  - Capture: byte k is captured from mem_rdata at T+2+k into bits [31-8k -: 8].
//    Out-of-range bytes capture 8'h00 and set the sticky err bit.
//  - Response:
//    - *_rsp_valid pulses exactly one cycle at T+6, on the granted port only.
//    - rdata/err are registered and hold until the next response on that port.
//    - No backpressure on responses.
//  - State is IDLE again at T+6, so a new handshake may occur at T+6: throughput is 1 word / 6 cycles.
//  - Handshake rule: a requester may drop valid only after ready. Dropping valid before grant is legal,
//    has no effect, and no response is produced.
//  - Reset mid-transaction aborts it. No response is produced for the in-flight request; the requester must reissue.
//  - mem_en is 0 in IDLE and DRAIN; mem_addr holds its last value.
// STRUCTURE
//  - Package rom_port_pkg:
//    - typedef enum {IDLE, ISSUE, DRAIN} rpa_state_e;
//    - typedef enum {REQ_IF, REQ_LD} req_id_e;
//    - localparams ROM_BASE_DEF and ROM_BYTES_DEF.
//  - Sub-module rom_rr_arbiter: 2-way round-robin grant plus pointer register. Everything else stays in this module.
// TESTING
//  1. Reset pulse mid-ISSUE (rst_n=0 at T+3):
//     all outputs 0 immediately; no rsp_valid follows; IF is granted first afterwards.
//  2. Single IF request, addr=BFC00000, ROM bytes 13,00,00,93:
//     if_req_ready at T; mem_addr 0..3 on T+1..T+4; if_rsp_valid at T+6 with rdata=32'h13000093, err=0.
//  3. IF and LD both valid continuously, addrs BFC00010/BFC00020:
//     grants alternate IF, LD, IF, LD; handshakes 6 cycles apart; each response arrives on the correct port.
//  4. LD addr=BFC00FFE (straddles end):
//     mem_en only for beats 0-1; rdata={b[FFE], b[FFF], 00, 00}; ld_err=1.
//  5. LD addr=FFFFFFFE:
//     mem_addr FFFFFFFE, FFFFFFFF, 00000000, 00000001 (wrap); mem_en 0 on all beats; rdata=0; err=1.

Source files
------------

// File: rtl/rom_port_pkg.sv
// Shared types and default ROM geometry for the boot-ROM port arbiter.
package rom_port_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rpa_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LD = 1'b1
  } req_id_e;

  localparam logic [31:0] ROM_BASE_DEF  = 32'hBFC0_0000;
  localparam int unsigned ROM_BYTES_DEF = 4096;

endpackage

// File: rtl/rom_rr_arbiter.sv
// Two-way round-robin grant for the IF and LD requesters; remembers the last winner.
module rom_rr_arbiter
  import rom_port_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_if_i,
  input  logic req_ld_i,
  output logic gnt_if_o,
  output logic gnt_ld_o
);

  req_id_e last_q, last_d;

  // On a tie the requester that did not win last time is granted.
  assign gnt_if_o = req_if_i & (~req_ld_i | (last_q == REQ_LD));
  assign gnt_ld_o = req_ld_i & (~req_if_i | (last_q == REQ_IF));

  always_comb begin
    last_d = last_q;
    if (gnt_if_o)      last_d = REQ_IF;
    else if (gnt_ld_o) last_d = REQ_LD;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= REQ_LD;
    else         last_q <= last_d;
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the byte-wide boot ROM read port between instruction fetch and data load;
// each grant reads four consecutive bytes and returns one big-endian 32-bit word.
module rom_port_arbiter
  import rom_port_pkg::*;
#(
  parameter int unsigned          A_WIDTH   = 32,
  parameter int unsigned          D_WIDTH   = 8,
  parameter logic [A_WIDTH-1:0]   ROM_BASE  = A_WIDTH'(ROM_BASE_DEF),
  parameter int unsigned          ROM_BYTES = ROM_BYTES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_req_valid,
  output logic                 if_req_ready,
  input  logic [A_WIDTH-1:0]   if_addr,
  output logic                 if_rsp_valid,
  output logic [4*D_WIDTH-1:0] if_rdata,
  output logic                 if_err,
  input  logic                 ld_req_valid,
  output logic                 ld_req_ready,
  input  logic [A_WIDTH-1:0]   ld_addr,
  output logic                 ld_rsp_valid,
  output logic [4*D_WIDTH-1:0] ld_rdata,
  output logic                 ld_err,
  output logic                 mem_en,
  output logic [A_WIDTH-1:0]   mem_addr,
  input  logic [D_WIDTH-1:0]   mem_rdata
);

  localparam int unsigned W_WIDTH = 4 * D_WIDTH;

  rpa_state_e           state_q, state_d;
  logic [1:0]           beat_q, beat_d;
  req_id_e              id_q, id_d;
  logic [A_WIDTH-1:0]   addr_q, addr_d;
  logic [A_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                 mem_en_q, mem_en_d;
  logic                 prev_ok_q, prev_ok_d;
  logic [W_WIDTH-1:0]   word_q, word_d;
  logic                 err_q, err_d;
  logic                 if_rsp_valid_q, if_rsp_valid_d, ld_rsp_valid_q, ld_rsp_valid_d;
  logic [W_WIDTH-1:0]   if_rdata_q, if_rdata_d, ld_rdata_q, ld_rdata_d;
  logic                 if_err_q, if_err_d, ld_err_q, ld_err_d;

  logic                 idle, gnt_if, gnt_ld, hs;
  logic [A_WIDTH-1:0]   req_addr, issue_addr;
  logic [1:0]           beat_inc, cap_idx;
  logic                 cap_en;
  logic [D_WIDTH-1:0]   cap_byte;
  logic [W_WIDTH-1:0]   word_cap;
  logic                 err_cap;

  function automatic logic in_rom(input logic [A_WIDTH-1:0] a);
    logic [A_WIDTH-1:0] off;
    off = a - ROM_BASE;
    return off < A_WIDTH'(ROM_BYTES);
  endfunction

  assign idle = (state_q == IDLE);

  // Requests are only visible to the arbiter while idle and out of reset.
  rom_rr_arbiter u_arb (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_if_i (if_req_valid & idle & rst_n),
    .req_ld_i (ld_req_valid & idle & rst_n),
    .gnt_if_o (gnt_if),
    .gnt_ld_o (gnt_ld)
  );

  assign hs         = gnt_if | gnt_ld;
  assign req_addr   = gnt_ld ? ld_addr : if_addr;
  assign beat_inc   = beat_q + 2'd1;
  assign issue_addr = addr_q + A_WIDTH'(beat_inc);

  // The byte arriving now belongs to the beat issued in the previous cycle.
  assign cap_en   = ((state_q == ISSUE) && (beat_q != 2'd0)) || (state_q == DRAIN);
  assign cap_idx  = (state_q == DRAIN) ? 2'd3 : (beat_q - 2'd1);
  assign cap_byte = prev_ok_q ? mem_rdata : '0;
  assign err_cap  = err_q | (cap_en & ~prev_ok_q);

  always_comb begin
    word_cap = word_q;
    case (cap_idx)
      2'd0:    word_cap[W_WIDTH-1             -: D_WIDTH] = cap_byte;
      2'd1:    word_cap[W_WIDTH-1-D_WIDTH     -: D_WIDTH] = cap_byte;
      2'd2:    word_cap[W_WIDTH-1-2*D_WIDTH   -: D_WIDTH] = cap_byte;
      default: word_cap[D_WIDTH-1             -: D_WIDTH] = cap_byte;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    id_d           = id_q;
    addr_d         = addr_q;
    mem_addr_d     = mem_addr_q;
    mem_en_d       = mem_en_q;
    prev_ok_d      = mem_en_q;
    word_d         = word_q;
    err_d          = err_q;
    if_rsp_valid_d = 1'b0;
    ld_rsp_valid_d = 1'b0;
    if_rdata_d     = if_rdata_q;
    ld_rdata_d     = ld_rdata_q;
    if_err_d       = if_err_q;
    ld_err_d       = ld_err_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d    = ISSUE;
          beat_d     = 2'd0;
          id_d       = gnt_ld ? REQ_LD : REQ_IF;
          addr_d     = req_addr;
          mem_addr_d = req_addr;
          mem_en_d   = in_rom(req_addr);
          word_d     = '0;
          err_d      = 1'b0;
        end
      end
      ISSUE: begin
        if (cap_en) begin
          word_d = word_cap;
          err_d  = err_cap;
        end
        if (beat_q == 2'd3) begin
          state_d  = DRAIN;
          mem_en_d = 1'b0;
        end else begin
          beat_d     = beat_inc;
          mem_addr_d = issue_addr;
          mem_en_d   = in_rom(issue_addr);
        end
      end
      DRAIN: begin
        state_d = IDLE;
        word_d  = word_cap;
        err_d   = err_cap;
        if (id_q == REQ_LD) begin
          ld_rsp_valid_d = 1'b1;
          ld_rdata_d     = word_cap;
          ld_err_d       = err_cap;
        end else begin
          if_rsp_valid_d = 1'b1;
          if_rdata_d     = word_cap;
          if_err_d       = err_cap;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      beat_q         <= 2'd0;
      id_q           <= REQ_IF;
      addr_q         <= '0;
      mem_addr_q     <= '0;
      mem_en_q       <= 1'b0;
      prev_ok_q      <= 1'b0;
      word_q         <= '0;
      err_q          <= 1'b0;
      if_rsp_valid_q <= 1'b0;
      ld_rsp_valid_q <= 1'b0;
      if_rdata_q     <= '0;
      ld_rdata_q     <= '0;
      if_err_q       <= 1'b0;
      ld_err_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      id_q           <= id_d;
      addr_q         <= addr_d;
      mem_addr_q     <= mem_addr_d;
      mem_en_q       <= mem_en_d;
      prev_ok_q      <= prev_ok_d;
      word_q         <= word_d;
      err_q          <= err_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      ld_rsp_valid_q <= ld_rsp_valid_d;
      if_rdata_q     <= if_rdata_d;
      ld_rdata_q     <= ld_rdata_d;
      if_err_q       <= if_err_d;
      ld_err_q       <= ld_err_d;
    end
  end

  assign if_req_ready = gnt_if;
  assign ld_req_ready = gnt_ld;
  assign if_rsp_valid = if_rsp_valid_q;
  assign ld_rsp_valid = ld_rsp_valid_q;
  assign if_rdata     = if_rdata_q;
  assign ld_rdata     = ld_rdata_q;
  assign if_err       = if_err_q;
  assign ld_err       = ld_err_q;
  assign mem_en       = mem_en_q;
  assign mem_addr     = mem_addr_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: vector table of single requests plus reset and tie sequences.
module tb_rom_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        ld_req_valid, ld_req_ready, ld_rsp_valid, ld_err;
  logic [31:0] ld_addr, ld_rdata;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;

  logic [7:0]  rom [4096];
  int          n_total = 0;
  int          n_pass  = 0;

  typedef struct {
    logic        is_ld;
    logic [31:0] addr;
    logic [3:0]  en;     // bit k = expected mem_en on beat k
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  rom_port_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_addr      (if_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rdata     (if_rdata),
    .if_err       (if_err),
    .ld_req_valid (ld_req_valid),
    .ld_req_ready (ld_req_ready),
    .ld_addr      (ld_addr),
    .ld_rsp_valid (ld_rsp_valid),
    .ld_rdata     (ld_rdata),
    .ld_err       (ld_err),
    .mem_en       (mem_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata)
  );

  // Synchronous byte ROM; junk on the bus when not enabled.
  always @(posedge clk) mem_rdata <= mem_en ? rom[mem_addr[11:0]] : 8'hEE;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  task automatic do_req(input vec_t v);
    logic rdy, oth, got, other_seen;
    int   n, lat;
    other_seen = 1'b0;
    got = 1'b0;
    @(negedge clk);
    if (v.is_ld) begin ld_addr = v.addr; ld_req_valid = 1'b1; end
    else begin if_addr = v.addr; if_req_valid = 1'b1; end
    #1;
    n = 0;
    rdy = v.is_ld ? ld_req_ready : if_req_ready;
    while (!rdy && n < 20) begin
      @(negedge clk); #1; n++;
      rdy = v.is_ld ? ld_req_ready : if_req_ready;
    end
    chk("req_ready", rdy, 1);
    oth = v.is_ld ? if_req_ready : ld_req_ready;
    chk("other_ready", oth, 0);
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    ld_req_valid = 1'b0;
    if (!rdy) return;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk($sformatf("beat%0d_addr", k), mem_addr, v.addr + k);
      chk($sformatf("beat%0d_en", k), mem_en, v.en[k]);
      if (v.is_ld ? if_rsp_valid : ld_rsp_valid) other_seen = 1'b1;
    end
    lat = 4;
    while (!got && lat < 12) begin
      @(negedge clk); #1; lat++;
      if (lat == 5) chk("drain_mem_en", mem_en, 0);
      if (v.is_ld ? ld_rsp_valid : if_rsp_valid) got = 1'b1;
      if (v.is_ld ? if_rsp_valid : ld_rsp_valid) other_seen = 1'b1;
    end
    chk("rsp_latency", lat, 6);
    chk("rsp_rdata", v.is_ld ? ld_rdata : if_rdata, v.rdata);
    chk("rsp_err", v.is_ld ? ld_err : if_err, v.err);
    chk("other_rsp", other_seen, 0);
    @(negedge clk); #1;
    chk("rsp_pulse_one", v.is_ld ? ld_rsp_valid : if_rsp_valid, 0);
  endtask

  initial begin
    int ng, nr, lastg, cnt;
    int gport [8];
    int gdue  [8];

    for (int i = 0; i < 4096; i++) rom[i] = i[7:0];
    rom[0] = 8'h13; rom[1] = 8'h00; rom[2] = 8'h00; rom[3] = 8'h93;

    vecs[0] = '{1'b0, 32'hBFC0_0000, 4'b1111, 32'h1300_0093, 1'b0};
    vecs[1] = '{1'b1, 32'hBFC0_0010, 4'b1111, 32'h1011_1213, 1'b0};
    vecs[2] = '{1'b0, 32'hBFC0_0101, 4'b1111, 32'h0102_0304, 1'b0};
    vecs[3] = '{1'b1, 32'hBFC0_0FFC, 4'b1111, 32'hFCFD_FEFF, 1'b0};
    vecs[4] = '{1'b1, 32'hBFC0_0FFE, 4'b0011, 32'hFEFF_0000, 1'b1};
    vecs[5] = '{1'b0, 32'hBFC0_0FFD, 4'b0111, 32'hFDFE_FF00, 1'b1};
    vecs[6] = '{1'b1, 32'hBFBF_FFFF, 4'b1110, 32'h0013_0000, 1'b1};
    vecs[7] = '{1'b1, 32'hFFFF_FFFE, 4'b0000, 32'h0000_0000, 1'b1};

    if_req_valid = 1'b0; ld_req_valid = 1'b0;
    if_addr = '0; ld_addr = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("reset_mem_en", mem_en, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_rsp", {if_rsp_valid, ld_rsp_valid}, 0);
    chk("reset_rdata", if_rdata | ld_rdata, 0);
    chk("reset_err", {if_err, ld_err}, 0);
    chk("reset_ready", {if_req_ready, ld_req_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) do_req(vecs[i]);

    // Reset asserted in the middle of an IF transaction.
    @(negedge clk);
    if_addr = 32'hBFC0_0010; if_req_valid = 1'b1;
    #1 chk("rst_pre_ready", if_req_ready, 1);
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("rst_pre_mem_addr", mem_addr, 32'hBFC0_0012);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_en", mem_en, 0);
    chk("rst_mid_mem_addr", mem_addr, 0);
    chk("rst_mid_if_rdata", if_rdata, 0);
    chk("rst_mid_err", {if_err, ld_err}, 0);
    chk("rst_mid_rsp", {if_rsp_valid, ld_rsp_valid}, 0);
    @(negedge clk);
    if_req_valid = 1'b1; ld_req_valid = 1'b1;
    #1 chk("rst_ready_held", {if_req_ready, ld_req_ready}, 0);
    @(negedge clk);
    if_req_valid = 1'b0; ld_req_valid = 1'b0;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (if_rsp_valid || ld_rsp_valid) cnt++;
    end
    chk("rst_no_rsp", cnt, 0);

    // Both requesters held valid: IF first after reset, then strict alternation.
    @(negedge clk);
    if_addr = 32'hBFC0_0010; ld_addr = 32'hBFC0_0020;
    if_req_valid = 1'b1; ld_req_valid = 1'b1;
    #1;
    chk("rst_if_first", {if_req_ready, ld_req_ready}, 2'b10);
    ng = 0; nr = 0; lastg = -100;
    for (int i = 0; i < 25; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      if (if_rsp_valid || ld_rsp_valid) begin
        if (nr < ng && nr < 8) begin
          chk("alt_rsp_port", {31'd0, ld_rsp_valid}, gport[nr]);
          chk("alt_rsp_time", i, gdue[nr]);
          chk("alt_rsp_rdata", ld_rsp_valid ? ld_rdata : if_rdata,
              (gport[nr] == 1) ? 32'h2021_2223 : 32'h1011_1213);
        end else begin
          chk("alt_unexpected_rsp", 1, 0);
        end
        nr++;
      end
      if (if_req_ready || ld_req_ready) begin
        chk("alt_exclusive", if_req_ready & ld_req_ready, 0);
        chk("alt_order", {31'd0, ld_req_ready}, ng % 2);
        if (ng > 0) chk("alt_gap", i - lastg, 6);
        if (ng < 8) begin
          gport[ng] = {31'd0, ld_req_ready};
          gdue[ng]  = i + 6;
        end
        ng++;
        lastg = i;
      end
    end
    // Drop both valids before the pending grant takes effect: nothing must follow.
    if_req_valid = 1'b0; ld_req_valid = 1'b0;
    chk("alt_grants", ng, 5);
    chk("alt_rsps", nr, 4);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (if_rsp_valid || ld_rsp_valid || mem_en) cnt++;
    end
    chk("drop_before_grant_quiet", cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
